// File: rtl/dsp_op_sequencer.sv
// dsp_op_sequencer
//   Issues operand sets into a free-running, fully pipelined DSP slice and
//   collects the results in a small FIFO. The DSP is never stalled (CE stays
//   high); when no command is issued, a zero-producing bubble is driven
//   instead. A tag shift register follows each command down the pipeline so
//   the result is captured exactly when it emerges. Commands are only
//   accepted while a FIFO slot is guaranteed for them, so the FIFO cannot
//   overflow. A flush discards everything and waits one full pipeline depth
//   (DRAIN) so that results of discarded commands are never captured.
//
// Ports
//   CLK, RST_N             clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake
//   cmd_a/b/c/d            command operands (18/18/48/18 bits)
//   cmd_opmode/carryin     command operation select and carry in
//   flush                  discard all in-flight and queued results
//   A/B/C/D/OPMODE/CARRYIN registered drive into the DSP slice
//   CE                     DSP clock enable (high whenever out of reset)
//   dsp_p, dsp_carryout    DSP result outputs
//   res_valid/res_ready    result handshake
//   res_p, res_carryout    result at the FIFO head
//   busy                   work in flight or queued, or draining
module dsp_op_sequencer #(
  parameter int LATENCY    = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [17:0] cmd_a,
  input  logic [17:0] cmd_b,
  input  logic [47:0] cmd_c,
  input  logic [17:0] cmd_d,
  input  logic [7:0]  cmd_opmode,
  input  logic        cmd_carryin,
  input  logic        flush,
  output logic [17:0] A,
  output logic [17:0] B,
  output logic [47:0] C,
  output logic [17:0] D,
  output logic [7:0]  OPMODE,
  output logic        CARRYIN,
  output logic        CE,
  input  logic [47:0] dsp_p,
  input  logic        dsp_carryout,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [47:0] res_p,
  output logic        res_carryout,
  output logic        busy
);

  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int ICW = $clog2(LATENCY + 1);
  localparam int DW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int SW  = ((ICW > FCW) ? ICW : FCW) + 1;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t             state;
  logic [LATENCY-1:0] tags;
  logic [ICW-1:0]     inflight_cnt;
  logic [FCW-1:0]     fifo_cnt;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [DW-1:0]      drain_cnt;
  logic [48:0]        fifo_mem [FIFO_DEPTH];
  logic [SW-1:0]      occupancy;
  logic               accept;
  logic               push;
  logic               pop;

  // Every accepted command owns a FIFO slot from issue until it is popped,
  // so the ready decision counts both in-flight and queued results.
  assign occupancy = SW'(inflight_cnt) + SW'(fifo_cnt);
  assign cmd_ready = RST_N && (state == RUN) && (occupancy < SW'(FIFO_DEPTH));

  // A flush wins over everything happening on the same edge.
  assign accept    = cmd_valid && cmd_ready && !flush;
  assign push      = tags[LATENCY-1] && !flush;
  assign pop       = res_valid && res_ready && !flush;

  assign CE        = RST_N;
  assign res_valid = (fifo_cnt != '0);
  assign busy      = (inflight_cnt != '0) || (fifo_cnt != '0) || (state == DRAIN);

  // Head is forced to zero when empty so stale entries never leak out.
  assign res_p        = res_valid ? fifo_mem[rd_ptr][47:0] : '0;
  assign res_carryout = res_valid ? fifo_mem[rd_ptr][48]   : 1'b0;

  // FIFO storage needs no reset: entries are only visible while counted.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {dsp_carryout, dsp_p};
    end
  end

  // Control state: RUN/DRAIN machine, DSP drive registers, tag pipeline,
  // in-flight counter and FIFO pointers. The drain counter is loaded with
  // LATENCY-1 so DRAIN lasts exactly LATENCY cycles before RUN resumes.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= RUN;
      tags         <= '0;
      inflight_cnt <= '0;
      fifo_cnt     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      drain_cnt    <= '0;
      A            <= '0;
      B            <= '0;
      C            <= '0;
      D            <= '0;
      OPMODE       <= '0;
      CARRYIN      <= 1'b0;
    end else begin
      A       <= accept ? cmd_a       : '0;
      B       <= accept ? cmd_b       : '0;
      C       <= accept ? cmd_c       : '0;
      D       <= accept ? cmd_d       : '0;
      OPMODE  <= accept ? cmd_opmode  : 8'h00;
      CARRYIN <= accept ? cmd_carryin : 1'b0;

      if (flush) begin
        tags         <= '0;
        inflight_cnt <= '0;
        fifo_cnt     <= '0;
        wr_ptr       <= '0;
        rd_ptr       <= '0;
      end else begin
        tags <= LATENCY'({tags, accept});

        case ({accept, tags[LATENCY-1]})
          2'b10:   inflight_cnt <= inflight_cnt + 1'b1;
          2'b01:   inflight_cnt <= inflight_cnt - 1'b1;
          default: inflight_cnt <= inflight_cnt;
        endcase

        if (push) begin
          wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        end

        case ({push, pop})
          2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
          2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
          default: fifo_cnt <= fifo_cnt;
        endcase
      end

      case (state)
        RUN: begin
          if (flush) begin
            state     <= DRAIN;
            drain_cnt <= DW'(LATENCY - 1);
          end
        end
        DRAIN: begin
          if (flush) begin
            drain_cnt <= DW'(LATENCY - 1);
          end else if (drain_cnt == '0) begin
            state <= RUN;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
